// File: rtl/yuv420_sram_frame_writer.sv
// yuv420_sram_frame_writer: writes packed 32b YUV420 pixel words into a ping-ponged 16b SRAM frame store
//
// Ports:
//   clk, resetb            clock (posedge) and async active-low reset
//   enable                 frame write enable, latched at FRAME_START only
//   dvi, dtypei, datai     input stream (valid, dtype, 32b packed pixel word)
//   addr, web, oeb         SRAM halfword address, write strobe (active low), output enable (held 1)
//   ram_drive, ram_datao   pad drive enable and SRAM write data
//   wr_buf                 buffer currently being written
//   frame_done, done_buf   1-cycle completion pulse and the buffer it completed
//   overflow               sticky per frame: a word was dropped (FIFO or buffer full)
//   words_last_frame       committed word count of the last completed frame
//
// Optional feature: define FRAME_WRITER_STATS_EN to build the committed-word counter;
// otherwise words_last_frame is tied to 0.
//
// The dtype encoding normally comes from dtypes.v; fallbacks are provided here.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 5
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 5'h01
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 5'h02
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 5'h0C
`endif

module yuv420_sram_frame_writer #(
  parameter int ADDR_WIDTH    = 21,
  parameter int BUF_HALFWORDS = 1 << 20,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    enable,
  input  logic                    dvi,
  input  logic [`DTYPE_WIDTH-1:0] dtypei,
  input  logic [31:0]             datai,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    web,
  output logic                    oeb,
  output logic                    ram_drive,
  output logic [15:0]             ram_datao,
  output logic                    wr_buf,
  output logic                    frame_done,
  output logic                    done_buf,
  output logic                    overflow,
  output logic [19:0]             words_last_frame
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BUF_HW = ADDR_WIDTH'(BUF_HALFWORDS);
  localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);
  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;
  state_t state;
  logic [31:0] mem [FIFO_DEPTH];
  logic [PW:0] wp, rp;
  logic [15:0] word_hi;
  logic [31:0] head;
  logic [ADDR_WIDTH-1:0] ptr, fill;
  logic frame_active, end_pending;
  logic fs, fe, pix, empty, full, room, push, drop, pop, done_now;
  // fill counts halfwords reserved at accept time, so the write pointer can never
  // run past the end of the current buffer even with words still queued.
  always_comb begin
    fs       = dvi && dtypei == `DTYPE_FRAME_START;
    fe       = dvi && dtypei == `DTYPE_FRAME_END && frame_active;
    pix      = dvi && |(dtypei & `DTYPE_PIXEL_MASK) && frame_active && !fs;
    empty    = wp == rp;
    full     = (wp - rp) == (PW + 1)'(FIFO_DEPTH);
    room     = fill <= BUF_HW - TWO;
    push     = pix && !full && room;
    drop     = pix && !push;
    pop      = !fs && !empty && state != WR_LO;
    done_now = !fs && end_pending && empty && state == IDLE;
    head     = mem[rp[PW-1:0]];
  end
  always_ff @(posedge clk)
    if (push) mem[wp[PW-1:0]] <= datai;
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      state        <= IDLE;
      wp           <= '0;
      rp           <= '0;
      word_hi      <= '0;
      ptr          <= '0;
      fill         <= '0;
      frame_active <= 1'b0;
      end_pending  <= 1'b0;
      addr         <= '0;
      web          <= 1'b1;
      oeb          <= 1'b1;
      ram_drive    <= 1'b0;
      ram_datao    <= '0;
      wr_buf       <= 1'b0;
      frame_done   <= 1'b0;
      done_buf     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      frame_done <= done_now;
      if (push) wp <= wp + 1'b1;
      if (push) fill <= fill + TWO;
      if (pop) rp <= rp + 1'b1;
      if (drop) overflow <= 1'b1;
      if (fe) end_pending <= 1'b1;
      if (fs) begin
        // The halfword already on the bus completes; its partner is abandoned.
        frame_active <= enable;
        end_pending  <= 1'b0;
        overflow     <= 1'b0;
        wp           <= '0;
        rp           <= '0;
        fill         <= '0;
        ptr          <= wr_buf ? BUF_HW : '0;
        state        <= IDLE;
        web          <= 1'b1;
        ram_drive    <= 1'b0;
      end else begin
        if (done_now) begin
          done_buf     <= wr_buf;
          wr_buf       <= !wr_buf;
          frame_active <= 1'b0;
          end_pending  <= 1'b0;
        end
        if (pop) begin
          word_hi   <= head[31:16];
          addr      <= ptr;
          ram_datao <= head[15:0];
          web       <= 1'b0;
          ram_drive <= 1'b1;
          state     <= WR_LO;
        end else if (state == WR_LO) begin
          addr      <= ptr + 1'b1;
          ram_datao <= word_hi;
          ptr       <= ptr + TWO;
          state     <= WR_HI;
        end else begin
          web       <= 1'b1;
          ram_drive <= 1'b0;
          state     <= IDLE;
        end
      end
    end
`ifdef FRAME_WRITER_STATS_EN
  logic [19:0] cnt;
  // A word counts once its high half is launched (WR_LO -> WR_HI).
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      cnt              <= '0;
      words_last_frame <= '0;
    end else begin
      if (fs) cnt <= '0;
      else if (state == WR_LO && cnt != '1) cnt <= cnt + 1'b1;
      if (done_now) words_last_frame <= cnt;
    end
`else
  assign words_last_frame = '0;
`endif
endmodule

// File: tb/tb_yuv420_sram_frame_writer.sv
// tb_yuv420_sram_frame_writer: randomized scoreboard bench for the SRAM frame writer
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 5
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 5'h01
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 5'h02
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 5'h0C
`endif

module tb_yuv420_sram_frame_writer;
  localparam int BUF = 1 << 20;
  localparam logic [`DTYPE_WIDTH-1:0] FS = `DTYPE_FRAME_START;
  localparam logic [`DTYPE_WIDTH-1:0] FE = `DTYPE_FRAME_END;
  localparam logic [`DTYPE_WIDTH-1:0] PY = 5'h04;
  localparam logic [`DTYPE_WIDTH-1:0] PUV = 5'h08;
  localparam logic [`DTYPE_WIDTH-1:0] ROWE = 5'h10;
  logic clk = 0, resetb = 0, enable = 0, dvi = 0;
  logic [`DTYPE_WIDTH-1:0] dtypei = '0;
  logic [31:0] datai = '0;
  logic [20:0] addr;
  logic web, oeb, ram_drive, wr_buf, frame_done, done_buf, overflow;
  logic [15:0] ram_datao;
  logic [19:0] words_last_frame;
  int n_pass = 0, n_total = 0, n_done = 0, n_writes = 0;
  logic [36:0] exp_q[$];
  logic [20:0] done_q[$];
  logic [36:0] got_q[$];
  logic [31:0] sent[$];
  bit free_mode = 0;
  int free_done = 0;
  logic free_buf;
  logic [19:0] free_words;
  bit m_buf = 0, m_active = 0;
  int m_n = 0;
  logic [36:0] e, lo, hi;
  logic [20:0] de, base;
  logic [31:0] w;
  int nw, j, snap_done, snap_writes;
  bit ok;

  always #5 clk = ~clk;

  yuv420_sram_frame_writer dut (
    .clk(clk), .resetb(resetb), .enable(enable), .dvi(dvi), .dtypei(dtypei), .datai(datai),
    .addr(addr), .web(web), .oeb(oeb), .ram_drive(ram_drive), .ram_datao(ram_datao),
    .wr_buf(wr_buf), .frame_done(frame_done), .done_buf(done_buf), .overflow(overflow),
    .words_last_frame(words_last_frame)
  );

  task automatic check(input string nm, input bit good, input longint act, input longint exp);
    n_total++;
    if (good) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [19:0] exp_words(input logic [19:0] n);
`ifdef FRAME_WRITER_STATS_EN
    return n;
`else
    return 20'd0 & n;
`endif
  endfunction

  always @(negedge clk) if (resetb) begin
    if (!web) begin
      n_writes++;
      check("oeb_high", oeb == 1'b1, oeb, 1);
      check("ram_drive", ram_drive == 1'b1, ram_drive, 1);
      if (free_mode) got_q.push_back({addr, ram_datao});
      else if (exp_q.size() == 0) check("unexpected_write", 1'b0, {addr, ram_datao}, 0);
      else begin
        e = exp_q.pop_front();
        check("write_addr_data", {addr, ram_datao} == e, {addr, ram_datao}, e);
      end
    end
    if (frame_done) begin
      n_done++;
      if (free_mode) begin
        free_done++;
        free_buf = done_buf;
        free_words = words_last_frame;
      end else if (done_q.size() == 0) check("unexpected_done", 1'b0, 1, 0);
      else begin
        de = done_q.pop_front();
        check("done_buf", done_buf == de[20], done_buf, de[20]);
        check("wr_buf_flip", wr_buf == !de[20], wr_buf, !de[20]);
        check("words_last_frame", words_last_frame == exp_words(de[19:0]), words_last_frame, exp_words(de[19:0]));
      end
    end
  end

  task automatic cyc(input logic [`DTYPE_WIDTH-1:0] dt, input logic [31:0] d);
    dvi = 1; dtypei = dt; datai = d;
    @(posedge clk); #1;
    dvi = 0; dtypei = '0; datai = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fstart(input bit en);
    enable = en;
    cyc(FS, $urandom);
    m_active = en;
    m_n = 0;
  endtask

  task automatic pixel(input logic [31:0] d);
    logic [20:0] a;
    a = (m_buf ? 21'(BUF) : 21'd0) + 21'(2 * m_n);
    if (free_mode) sent.push_back(d);
    else if (m_active) begin
      exp_q.push_back({a, d[15:0]});
      exp_q.push_back({a + 21'd1, d[31:16]});
      m_n++;
    end
    cyc($urandom_range(1) ? PY : PUV, d);
  endtask

  task automatic fend();
    cyc(FE, $urandom);
    if (m_active && !free_mode) begin
      done_q.push_back({m_buf, 20'(m_n)});
      m_buf = !m_buf;
      m_active = 0;
    end
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 400 && (exp_q.size() != 0 || done_q.size() != 0); i++) @(posedge clk);
    #1;
    check(nm, exp_q.size() == 0 && done_q.size() == 0, exp_q.size() + done_q.size(), 0);
    idle(3);
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_addr"}, addr == 21'd0, addr, 0);
    check({nm, "_web"}, web == 1'b1, web, 1);
    check({nm, "_oeb"}, oeb == 1'b1, oeb, 1);
    check({nm, "_drive"}, ram_drive == 1'b0, ram_drive, 0);
    check({nm, "_datao"}, ram_datao == 16'd0, ram_datao, 0);
    check({nm, "_bufs"}, {wr_buf, done_buf, frame_done, overflow} == 4'd0, {wr_buf, done_buf, frame_done, overflow}, 0);
    check({nm, "_words"}, words_last_frame == 20'd0, words_last_frame, 0);
  endtask

  initial begin
    #23;
    check_reset("reset");
    @(posedge clk); #1;
    resetb = 1;
    idle(2);
    fstart(1);
    pixel(32'h11223344);
    pixel(32'h55667788);
    pixel(32'h99AABBCC);
    fend();
    wait_drain("frame0_drain");
    check("frame0_wr_buf", wr_buf == 1'b1, wr_buf, 1);
    fstart(1);
    pixel(32'hDEADBEEF);
    fend();
    wait_drain("frame1_drain");
    check("frame1_wr_buf", wr_buf == 1'b0, wr_buf, 0);
    snap_done = n_done; snap_writes = n_writes;
    fstart(0);
    pixel($urandom);
    pixel($urandom);
    enable = 1;
    pixel($urandom);
    pixel($urandom);
    fend();
    idle(30);
    check("disabled_no_write", n_writes == snap_writes, n_writes - snap_writes, 0);
    check("disabled_no_done", n_done == snap_done, n_done - snap_done, 0);
    check("disabled_wr_buf", wr_buf == m_buf, wr_buf, m_buf);
    for (int f = 0; f < 6; f++) begin
      fstart(1);
      nw = $urandom_range(1, 40);
      for (int i = 0; i < nw; i++) begin
        pixel($urandom);
        if ($urandom_range(3) == 0) cyc(ROWE, $urandom);
        if (i % 6 == 5) idle(12);
        else idle($urandom_range(0, 2));
      end
      fend();
      wait_drain("rand_drain");
      check("rand_no_overflow", overflow == 1'b0, overflow, 0);
    end
    free_mode = 1; free_done = 0;
    got_q.delete(); sent.delete();
    fstart(1);
    base = m_buf ? 21'(BUF) : 21'd0;
    for (int i = 0; i < 32; i++) pixel($urandom);
    fend();
    for (int i = 0; i < 300 && free_done == 0; i++) @(posedge clk);
    #1;
    idle(4);
    check("ovf_sticky", overflow == 1'b1, overflow, 1);
    check("ovf_even", got_q.size() % 2 == 0, got_q.size(), 0);
    nw = got_q.size() / 2;
    check("ovf_count", nw >= 8 && nw < 32, nw, 8);
    ok = 1; j = 0;
    for (int k = 0; k < nw; k++) begin
      lo = got_q[2 * k];
      hi = got_q[2 * k + 1];
      if (lo[36:16] != base + 21'(2 * k) || hi[36:16] != base + 21'(2 * k + 1)) ok = 0;
      w = {hi[15:0], lo[15:0]};
      while (j < sent.size() && sent[j] != w) j++;
      if (j == sent.size()) ok = 0;
      else j++;
    end
    check("ovf_words_in_order", ok, ok, 1);
    check("ovf_done_once", free_done == 1, free_done, 1);
    check("ovf_done_buf", free_buf == m_buf, free_buf, m_buf);
    check("ovf_words_last", free_words == exp_words(20'(nw)), free_words, exp_words(20'(nw)));
    m_buf = !m_buf; m_active = 0; free_mode = 0;
    fstart(1);
    check("ovf_cleared", overflow == 1'b0, overflow, 0);
    fend();
    wait_drain("empty_frame_drain");
    fstart(1);
    for (int i = 0; i < 6; i++) pixel($urandom);
    #2;
    resetb = 0;
    #1;
    check_reset("async_reset");
    exp_q.delete(); done_q.delete();
    m_buf = 0; m_active = 0;
    idle(2);
    resetb = 1;
    idle(2);
    fstart(1);
    pixel(32'hCAFEF00D);
    fend();
    wait_drain("post_reset_drain");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
